// File: rtl/dac_spi_tx.sv
// SPI transmitter for a 16-bit DAC: one-deep sample holding register, optional
// two's-complement to offset-binary conversion, CS/SCLK/MOSI generation and overrun flag.
module dac_spi_tx #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 2,
  parameter int CS_HIGH       = 2,
  parameter bit OFFSET_BINARY = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  output logic              sample_ready,
  input  logic              overrun_clr,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              busy,
  output logic              overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [DATA_W-1:0] CONV_MASK = {OFFSET_BINARY, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic                sample_ready_q, sample_ready_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                accept, drop;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    shift_d      = shift_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    accept       = sample_valid && sample_ready_q;
    drop         = sample_valid && !sample_ready_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          cs_n_d      = 1'b0;
          mosi_d      = hold_q[DATA_W-1];
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          sclk_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Falling edge of the last bit closes the frame; otherwise advance MOSI.
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              cs_n_d    = 1'b1;
              gap_cnt_d = '0;
              state_d   = GAP;
            end else begin
              shift_d   = shift_q << 1;
              mosi_d    = shift_q[DATA_W-2];
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(CS_HIGH - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is low during the IDLE load cycle, so accept never collides with a load.
    if (accept) begin
      hold_d      = sample ^ CONV_MASK;
      hold_full_d = 1'b1;
    end

    if (drop)             overrun_d = 1'b1;
    else if (overrun_clr) overrun_d = 1'b0;

    sample_ready_d = !hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      sample_ready_q <= 1'b1;
      shift_q        <= '0;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      cs_n_q         <= 1'b1;
      sclk_q         <= 1'b0;
      mosi_q         <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      sample_ready_q <= sample_ready_d;
      shift_q        <= shift_d;
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      cs_n_q         <= cs_n_d;
      sclk_q         <= sclk_d;
      mosi_q         <= mosi_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three configurations (defaults, no conversion, fast divider)
// with an SPI monitor and an arithmetic model of conversion and acceptance timing.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  vld;
  logic [15:0] sample;
  logic        clr;
  wire  [2:0]  rdy, cs_n, sclk, mosi, bsy, ovr;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  dac_spi_tx u0 (
    .clk(clk), .reset(reset), .sample_valid(vld[0]), .sample(sample), .sample_ready(rdy[0]),
    .overrun_clr(clr), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]),
    .busy(bsy[0]), .overrun(ovr[0]));

  dac_spi_tx #(.OFFSET_BINARY(1'b0)) u1 (
    .clk(clk), .reset(reset), .sample_valid(vld[1]), .sample(sample), .sample_ready(rdy[1]),
    .overrun_clr(clr), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]),
    .busy(bsy[1]), .overrun(ovr[1]));

  dac_spi_tx #(.CLK_DIV(1), .CS_HIGH(1)) u2 (
    .clk(clk), .reset(reset), .sample_valid(vld[2]), .sample(sample), .sample_ready(rdy[2]),
    .overrun_clr(clr), .dac_cs_n(cs_n[2]), .dac_sclk(sclk[2]), .dac_mosi(mosi[2]),
    .busy(bsy[2]), .overrun(ovr[2]));

  // SPI monitor, sampled on the falling clk edge.
  logic [15:0] cap [3][$];
  int          lens [3][$];
  int          nbits [3][$];
  logic [15:0] sh [3];
  int          nb [3], lowc [3], highc [3];
  int          rises [3] = '{0, 0, 0};
  int          last_gap [3] = '{0, 0, 0};
  bit          prev_cs [3] = '{1, 1, 1};
  bit          prev_sc [3] = '{0, 0, 0};
  bit          have_prev [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!prev_sc[i] && sclk[i]) rises[i]++;
      if (reset) begin
        sh[i] = '0; nb[i] = 0; lowc[i] = 0; highc[i] = 0; have_prev[i] = 0;
      end else begin
        if (!prev_sc[i] && sclk[i] && !cs_n[i]) begin
          sh[i] = {sh[i][14:0], mosi[i]};
          nb[i]++;
        end
        if (!cs_n[i]) begin
          if (prev_cs[i] && have_prev[i]) last_gap[i] = highc[i];
          lowc[i]++;
        end else begin
          if (!prev_cs[i]) begin
            cap[i].push_back(sh[i]);
            lens[i].push_back(lowc[i]);
            nbits[i].push_back(nb[i]);
            sh[i] = '0; nb[i] = 0; lowc[i] = 0; highc[i] = 0; have_prev[i] = 1;
          end
          highc[i]++;
        end
      end
      prev_cs[i] = cs_n[i];
      prev_sc[i] = sclk[i];
    end
  end

  // Reference: offset binary is the two's-complement value plus half scale, mod 2^16.
  function automatic logic [15:0] conv(input logic [15:0] s, input bit ob);
    return ob ? 16'(s + 16'h8000) : s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic send(input int i, input logic [15:0] v);
    int n = 0;
    while (rdy[i] !== 1'b1 && n < 300) begin tick(); n++; end
    if (rdy[i] !== 1'b1) begin timeout("send_ready"); return; end
    sample = v;
    vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (bsy[i] !== 1'b0 && n < 300) begin tick(); n++; end
    if (bsy[i] !== 1'b0) timeout("wait_idle");
    tick();
  endtask

  task automatic expect_frame(input int i, input logic [15:0] exp, input int explen,
                              input string tag);
    int n = 0;
    while (cap[i].size() == 0 && n < 400) begin tick(); n++; end
    if (cap[i].size() == 0) begin timeout(tag); return; end
    chk({tag, "_word"}, 32'(cap[i].pop_front()), 32'(exp));
    chk({tag, "_cslow"}, 32'(lens[i].pop_front()), 32'(explen));
    chk({tag, "_bits"}, 32'(nbits[i].pop_front()), 32'd16);
  endtask

  initial begin
    logic [15:0] r, v0, x, y;
    int offs[$];
    int rise0;

    #2ms;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r, r2, v0, x;
    int offs[$];
    int rise0;
    reset = 1'b1; vld = '0; sample = '0; clr = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rst_sclk", 32'(sclk[0]), 32'd0);
    chk("rst_mosi", 32'(mosi[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_busy", 32'(bsy[0]), 32'd0);
    chk("rst_ovr", 32'(ovr[0]), 32'd0);
    reset = 1'b0;
    tick();

    // First-acceptance latency on defaults, sample 16'h8000.
    sample = 16'h8000; vld[0] = 1'b1;
    tick();
    vld[0] = 1'b0;
    chk("acc_ready_low", 32'(rdy[0]), 32'd0);
    chk("acc_cs_still_high", 32'(cs_n[0]), 32'd1);
    tick();
    chk("load_cs_low", 32'(cs_n[0]), 32'd0);
    chk("load_mosi_msb", 32'(mosi[0]), 32'(conv(16'h8000, 1'b1) >> 15));
    chk("load_busy", 32'(bsy[0]), 32'd1);
    chk("load_ready", 32'(rdy[0]), 32'd1);
    expect_frame(0, conv(16'h8000, 1'b1), 64, "conv8000");

    send(0, 16'h7FFF);
    expect_frame(0, conv(16'h7FFF, 1'b1), 64, "conv7fff");
    send(0, 16'h1234);
    expect_frame(0, conv(16'h1234, 1'b1), 64, "conv1234");
    for (int k = 0; k < 3; k++) begin
      r = 16'($urandom);
      send(0, r);
      expect_frame(0, conv(r, 1'b1), 64, "conv_rand");
    end

    // No conversion.
    send(1, 16'h1234);
    expect_frame(1, conv(16'h1234, 1'b0), 64, "raw1234");
    r = 16'($urandom);
    send(1, r);
    expect_frame(1, conv(r, 1'b0), 64, "raw_rand");

    // Back-to-back on defaults.
    wait_idle(0);
    send(0, 16'hA5A5);
    send(0, 16'h5A5A);
    expect_frame(0, conv(16'hA5A5, 1'b1), 64, "b2b_a");
    expect_frame(0, conv(16'h5A5A, 1'b1), 64, "b2b_b");
    chk("b2b_cs_gap", 32'(last_gap[0]), 32'd3);
    chk("b2b_no_ovr", 32'(ovr[0]), 32'd0);

    // Fast divider, two back-to-back frames: 32 low + 2 high = 34-cycle period.
    r2 = 16'($urandom);
    send(2, 16'h0001);
    send(2, r2);
    expect_frame(2, conv(16'h0001, 1'b1), 32, "div_0001");
    expect_frame(2, conv(r2, 1'b1), 32, "div_rand");
    chk("div_cs_gap", 32'(last_gap[2]), 32'd2);

    // Continuous valid with incrementing data from an idle, empty DUT.
    // Accepts at offset 0, then the cycle after each load (1 + 67k).
    wait_idle(0);
    v0 = 16'($urandom);
    offs.push_back(0);
    for (int o = 2; o < 150; o += 67) offs.push_back(o);
    for (int i = 0; i < 150; i++) begin
      sample = 16'(v0 + 16'(i));
      vld[0] = 1'b1;
      tick();
      if (i == 0) chk("ovr_before_drop", 32'(ovr[0]), 32'd0);
      if (i == 1) chk("ovr_after_drop", 32'(ovr[0]), 32'd1);
    end
    vld[0] = 1'b0;
    foreach (offs[k]) expect_frame(0, conv(16'(v0 + 16'(offs[k])), 1'b1), 64, "ovr_frame");
    wait_idle(0);
    chk("ovr_no_extra", 32'(cap[0].size()), 32'd0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovr_clear", 32'(ovr[0]), 32'd0);

    // Drop in the IDLE load cycle together with clear: set wins.
    x = 16'($urandom);
    send(0, x);
    sample = ~x; vld[0] = 1'b1; clr = 1'b1;
    tick();
    vld[0] = 1'b0; clr = 1'b0;
    chk("drop_clr_ovr", 32'(ovr[0]), 32'd1);
    expect_frame(0, conv(x, 1'b1), 64, "drop_keep");
    wait_idle(0);
    chk("drop_not_sent", 32'(cap[0].size()), 32'd0);

    // Reset mid-frame.
    send(0, 16'($urandom));
    repeat (20) tick();
    reset = 1'b1;
    tick();
    rise0 = rises[0];
    chk("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("mid_rst_sclk", 32'(sclk[0]), 32'd0);
    chk("mid_rst_ready", 32'(rdy[0]), 32'd1);
    chk("mid_rst_ovr", 32'(ovr[0]), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (200) tick();
    chk("mid_rst_no_sclk", 32'(rises[0]), 32'(rise0));
    chk("mid_rst_no_frame", 32'(cap[0].size()), 32'd0);
    chk("mid_rst_cs_idle", 32'(cs_n[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
